mmio_tx_port: RTL and testbench

MMIO_TX_PORT -- requirements
Module: mmio_tx_port

---
 rtl/mmio_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 51 +++++
 rtl/mmio_tx_port.sv | 110 +++++++++++
 tb/tb_mmio_tx_port.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO transmit port: register offsets and STATUS bit layout.
package mmio_pkg;

   localparam logic [1:0] REG_TX_DATA = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_TIMER   = 2'd2;
   localparam logic [1:0] REG_COMPARE = 2'd3;

   // Read-side STATUS positions; count occupies [4:0], bit 5 reads as zero.
   localparam int unsigned STAT_EMPTY_BIT = 6;
   localparam int unsigned STAT_FULL_BIT  = 7;
   localparam int unsigned STAT_OVF_BIT   = 8;
   localparam int unsigned STAT_MATCH_BIT = 9;

   // Write-side clear strobes sit one bit above their read positions.
   localparam int unsigned CLR_OVF_BIT   = 9;
   localparam int unsigned CLR_MATCH_BIT = 10;

   function automatic logic [31:0] status_word(input logic match, input logic overflow,
                                               input logic full, input logic empty,
                                               input logic [4:0] count);
      logic [31:0] w_s;
      w_s                 = '0;
      w_s[4:0]            = count;
      w_s[STAT_EMPTY_BIT] = empty;
      w_s[STAT_FULL_BIT]  = full;
      w_s[STAT_OVF_BIT]   = overflow;
      w_s[STAT_MATCH_BIT] = match;
      return w_s;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted only
// when a pop happens in the same cycle. Head reads as zero while empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign full    = (r_count == CW'(DEPTH));
   assign empty   = (r_count == '0);
   assign count   = r_count;
   assign w_pop   = pop && !empty;
   assign w_push  = push && (!full || w_pop);
   assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

   // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_push) r_mem[r_wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/mmio_tx_port.sv
// Memory-mapped byte transmit port: TX FIFO, STATUS flags, free-running TIMER and
// COMPARE with a sticky match flag, all in one 16-byte register window.
module mmio_tx_port
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic        write_enable,
   output logic [31:0] read_data,
   output logic        hit,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic          w_hit;
   logic [1:0]    w_offset;
   logic          w_wr;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [7:0]    w_head;
   logic          w_unused_addr;
   logic          w_ovf_set;
   logic          w_match_set;
   logic [31:0]   r_timer;
   logic [31:0]   r_compare;
   logic          r_overflow;
   logic          r_match;

   assign w_hit         = (addr[31:4] == BASE_ADDR[31:4]);
   assign w_offset      = addr[3:2];
   assign w_unused_addr = ^addr[1:0];
   assign w_wr          = write_enable && clk_enable && w_hit;
   assign w_push        = w_wr && (w_offset == REG_TX_DATA);
   assign w_pop         = tx_valid && tx_ready;
   assign w_ovf_set     = w_push && w_full && !w_pop;
   assign w_match_set   = clk_enable && (r_timer == r_compare);

   assign hit      = w_hit;
   assign tx_valid = !w_empty;
   assign tx_data  = w_head;

   sync_fifo #(
      .WIDTH(8),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (w_push),
      .pop    (w_pop),
      .wr_data(write_data[7:0]),
      .rd_data(w_head),
      .full   (w_full),
      .empty  (w_empty),
      .count  (w_count)
   );

   // A match set in the same cycle as a STATUS clear wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_timer    <= '0;
         r_compare  <= '0;
         r_overflow <= 1'b0;
         r_match    <= 1'b0;
      end else begin
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end else if (w_wr && (w_offset == REG_STATUS) && write_data[CLR_OVF_BIT]) begin
            r_overflow <= 1'b0;
         end
         if (w_match_set) begin
            r_match <= 1'b1;
         end else if (w_wr && (w_offset == REG_STATUS) && write_data[CLR_MATCH_BIT]) begin
            r_match <= 1'b0;
         end
         if (w_wr && (w_offset == REG_TIMER)) begin
            r_timer <= write_data;
         end else if (clk_enable) begin
            r_timer <= r_timer + 32'd1;
         end
         if (w_wr && (w_offset == REG_COMPARE)) r_compare <= write_data;
      end
   end

   always_comb begin
      read_data = '0;
      if (w_hit) begin
         unique case (w_offset)
            REG_TX_DATA: read_data = {24'b0, w_head};
            REG_STATUS:  read_data = status_word(r_match, r_overflow, w_full, w_empty,
                                                 5'(w_count));
            REG_TIMER:   read_data = r_timer;
            REG_COMPARE: read_data = r_compare;
            default:     read_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_tx_port.sv
// Directed and randomized bench for mmio_tx_port, checked against a queue-based model.
module tb_mmio_tx_port;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_enable;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        write_enable;
   logic [31:0] read_data;
   logic        hit;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   logic [7:0]  q[$];
   logic [31:0] m_timer;
   logic [31:0] m_compare;
   logic        m_ovf;
   logic        m_match;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   mmio_tx_port #(
      .BASE_ADDR (BASE),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clk_enable  (clk_enable),
      .addr        (addr),
      .write_data  (write_data),
      .write_enable(write_enable),
      .read_data   (read_data),
      .hit         (hit),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [31:0] a);
      logic [31:0] s;
      if (a[31:4] != BASE[31:4]) return 32'h0;
      case (a[3:2])
         2'd0: return (q.size() != 0) ? {24'h0, q[0]} : 32'h0;
         2'd1: begin
            s       = 32'h0;
            s[4:0]  = 5'(q.size());
            s[6]    = (q.size() == 0);
            s[7]    = (q.size() == DEPTH);
            s[8]    = m_ovf;
            s[9]    = m_match;
            return s;
         end
         2'd2:    return m_timer;
         default: return m_compare;
      endcase
   endfunction

   function automatic logic [7:0] exp_head();
      return (q.size() != 0) ? q[0] : 8'h00;
   endfunction

   // One bus cycle: drive on the falling edge, check outputs, advance the model at the edge.
   task automatic step(input logic we, input logic ce, input logic rdy, input logic [31:0] a,
                       input logic [31:0] wd);
      logic       hm;
      logic [1:0] off;
      logic       wr;
      logic       pop;
      logic       was_full;
      logic       mset;
      @(negedge clk);
      write_enable = we;
      clk_enable   = ce;
      tx_ready     = rdy;
      addr         = a;
      write_data   = wd;
      #1;
      hm = (a[31:4] == BASE[31:4]);
      chk("hit", {31'h0, hit}, {31'h0, hm});
      chk("read_data", read_data, exp_read(a));
      chk("tx_valid", {31'h0, tx_valid}, {31'h0, (q.size() != 0)});
      chk("tx_data", {24'h0, tx_data}, {24'h0, exp_head()});
      off      = a[3:2];
      wr       = we && ce && hm;
      pop      = (q.size() != 0) && rdy;
      was_full = (q.size() == DEPTH);
      mset     = ce && (m_timer == m_compare);
      if (pop) void'(q.pop_front());
      if (wr && off == 2'd0) begin
         if (!was_full || pop) q.push_back(wd[7:0]);
         else m_ovf = 1'b1;
      end
      if (wr && off == 2'd1) begin
         if (wd[9])  m_ovf   = 1'b0;
         if (wd[10]) m_match = 1'b0;
      end
      if (mset) m_match = 1'b1;
      if (wr && off == 2'd2) m_timer = wd;
      else if (ce) m_timer = m_timer + 32'd1;
      if (wr && off == 2'd3) m_compare = wd;
      @(posedge clk);
   endtask

   task automatic wr(input logic [1:0] off, input logic [31:0] wd);
      step(1'b1, 1'b1, 1'b0, BASE + {28'h0, off, 2'b00}, wd);
   endtask

   // Idle look: the following edge has clk_enable, write_enable and tx_ready all low.
   task automatic look(input logic [31:0] a);
      @(negedge clk);
      write_enable = 1'b0;
      clk_enable   = 1'b0;
      tx_ready     = 1'b0;
      addr         = a;
      #1;
   endtask

   // Reset with a TX_DATA push pending in the same cycle; the push must be discarded.
   task automatic do_reset();
      @(negedge clk);
      reset        = 1'b1;
      write_enable = 1'b1;
      clk_enable   = 1'b1;
      tx_ready     = 1'b0;
      addr         = BASE;
      write_data   = 32'h99;
      @(posedge clk);
      q.delete();
      m_timer   = 32'h0;
      m_compare = 32'h0;
      m_ovf     = 1'b0;
      m_match   = 1'b0;
      @(negedge clk);
      reset        = 1'b0;
      write_enable = 1'b0;
      clk_enable   = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] wd;
      reset = 1'b1; clk_enable = 1'b0; write_enable = 1'b0; tx_ready = 1'b0;
      addr = 32'h0; write_data = 32'h0;

      do_reset();
      look(BASE + 32'h4);
      chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
      chk("rst_status", read_data, 32'h0000_0040);

      wr(2'd0, 32'h41);
      wr(2'd0, 32'h42);
      look(BASE + 32'h4);
      chk("two_valid", {31'h0, tx_valid}, 32'h1);
      chk("two_head", {24'h0, tx_data}, 32'h41);
      chk("two_count", {27'h0, read_data[4:0]}, 32'd2);

      do_reset();
      for (int i = 0; i < 9; i++) wr(2'd0, 32'h10 + i);
      look(BASE + 32'h4);
      chk("ovf_full", {31'h0, read_data[7]}, 32'h1);
      chk("ovf_count", {27'h0, read_data[4:0]}, 32'd8);
      chk("ovf_flag", {31'h0, read_data[8]}, 32'h1);
      wr(2'd1, 32'h200);
      look(BASE + 32'h4);
      chk("ovf_clear", {31'h0, read_data[8]}, 32'h0);

      step(1'b1, 1'b1, 1'b1, BASE, 32'hA0);
      look(BASE + 32'h4);
      chk("pushpop_full_count", {27'h0, read_data[4:0]}, 32'd8);
      chk("pushpop_no_ovf", {31'h0, read_data[8]}, 32'h0);
      for (int i = 0; i < 8; i++) begin
         look(BASE);
         chk("drain_order", {24'h0, tx_data}, (i < 7) ? 32'h11 + i : 32'hA0);
         step(1'b0, 1'b0, 1'b1, BASE + 32'h4, 32'h0);
      end
      look(BASE);
      chk("drained_valid", {31'h0, tx_valid}, 32'h0);

      do_reset();
      wr(2'd3, 32'h5);
      wr(2'd2, 32'hFFFF_FFFE);
      wr(2'd1, 32'h400);
      wr(2'd3, 32'h0);
      look(BASE + 32'h8);
      chk("timer_wrapped", read_data, 32'h0);
      look(BASE + 32'h4);
      chk("match_not_yet", {31'h0, read_data[9]}, 32'h0);
      step(1'b0, 1'b1, 1'b0, BASE + 32'h4, 32'h0);
      look(BASE + 32'h4);
      chk("match_set", {31'h0, read_data[9]}, 32'h1);
      step(1'b1, 1'b0, 1'b0, BASE + 32'hC, 32'h1234);
      step(1'b1, 1'b0, 1'b0, BASE + 32'h8, 32'h5678);
      look(BASE + 32'hC);
      chk("gated_compare", read_data, 32'h0);
      look(BASE + 32'h8);
      chk("gated_timer", read_data, 32'h1);

      look(BASE + 32'h10);
      chk("miss_hit", {31'h0, hit}, 32'h0);
      chk("miss_data", read_data, 32'h0);
      look(BASE - 32'h4);
      chk("miss_below", {31'h0, hit}, 32'h0);

      do_reset();
      for (int i = 0; i < 5; i++) wr(2'd0, 32'h60 + i);
      look(BASE + 32'h3);
      chk("low_bits_ignored", read_data, 32'h60);
      do_reset();
      look(BASE + 32'h4);
      chk("flush_valid", {31'h0, tx_valid}, 32'h0);
      chk("flush_status", read_data, 32'h0000_0040);
      look(BASE + 32'h8);
      chk("flush_timer", read_data, 32'h0);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            a  = ($urandom_range(0, 7) == 0) ? $urandom : BASE + $urandom_range(0, 15);
            wd = ($urandom_range(0, 3) == 0) ? m_compare - $urandom_range(0, 3) : $urandom;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0), a, wd);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
